hamming_mem_engine: RTL and testbench

- Parametrised SECDED Hamming codec engine with direct access to the byte-wide data memory.
- On a req pulse it walks NUM_MSG words. In encode mode it reads raw data words and writes the matching codewords. In decode mode it reads codewords and writes corrected data words.
- It also counts corrected single errors and uncorrectable double errors.
- It is the hardware successor to the software parity-insert (program 1) and parity-correct (program 2) routines, and sits beside data_mem1 under TopLevel.

---
 rtl/hamming_mem_engine_if.sv | 18 +
 rtl/hamming_mem_engine.sv | 183 ++++++++++++++++++
 tb/tb_hamming_mem_engine.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_mem_engine_if.sv
// Request/memory bus of the SECDED codec engine: job handshake, byte-wide memory port, error counters.
interface hamming_mem_engine_if #(parameter int ADDR_W = 8);
  logic              req;
  logic              mode;
  logic              ack;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic [7:0]        corr_cnt;
  logic [7:0]        dbl_cnt;

  modport master (output req, mode, mem_rd_data,
                  input  ack, busy, mem_addr, mem_wr_en, mem_wr_data, corr_cnt, dbl_cnt);
  modport slave  (input  req, mode, mem_rd_data,
                  output ack, busy, mem_addr, mem_wr_en, mem_wr_data, corr_cnt, dbl_cnt);
endinterface

// File: rtl/hamming_mem_engine.sv
// SECDED Hamming encode/decode engine walking NUM_MSG words in byte-wide memory.
// Optional build macro HAMMING_ERR_FLAG_EN adds dbl/corr flags to the top bits of decoded words.
module hamming_mem_engine #(
  parameter int DATA_W   = 11,
  parameter int NUM_MSG  = 15,
  parameter int ADDR_W   = 8,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 30
) (
  input  logic clk,
  input  logic reset,
  hamming_mem_engine_if.slave bus
);
  function automatic int calc_p(input int dw);
    for (int p = 1; p < 32; p++) if ((1 << p) >= dw + p + 1) return p;
    return 0;
  endfunction

  localparam int P  = calc_p(DATA_W);
  localparam int CW = DATA_W + P + 1;
  localparam int DB = (DATA_W + 7) / 8;
  localparam int CB = (CW + 7) / 8;
  localparam int AW = 8 * CB;

`ifdef HAMMING_ERR_FLAG_EN
  if (8 * DB - DATA_W < 2) begin : g_flag_chk
    $error("hamming_mem_engine: no room for error flags above DATA_W");
  end
`endif

  typedef enum logic [2:0] {IDLE, RD, CALC, WR, DONE} state_t;

  state_t          state, state_n;
  logic [7:0]      idx;
  logic [1:0]      bcnt;
  logic [AW-1:0]   asm_q, out_q;
  logic            mode_q;
  logic [7:0]      corr_q, dbl_q;

  // Data bits occupy the non-power-of-two positions in ascending order.
  function automatic logic [CW-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW-1:0] c;
    int n;
    c = '0;
    n = 0;
    for (int k = 1; k < CW; k++) if ((k & (k - 1)) != 0) begin c[k] = d[n]; n++; end
    for (int j = 0; j < P; j++)
      for (int k = 1; k < CW; k++)
        if ((((k >> j) & 1) == 1) && ((k & (k - 1)) != 0)) c[1 << j] = c[1 << j] ^ c[k];
    c[0] = ^c[CW-1:1];
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CW-1:0] c);
    logic [DATA_W-1:0] d;
    int n;
    d = '0;
    n = 0;
    for (int k = 1; k < CW; k++) if ((k & (k - 1)) != 0) begin d[n] = c[k]; n++; end
    return d;
  endfunction

  logic [P-1:0]  syn;
  logic          par;
  logic [CW-1:0] fixed;
  logic          is_corr, is_dbl;
  logic [AW-1:0] dec_word, enc_word;

  always_comb begin
    syn = '0;
    for (int k = 1; k < CW; k++) if (asm_q[k]) syn = syn ^ P'(k);
    par     = ^asm_q[CW-1:0];
    fixed   = asm_q[CW-1:0];
    is_corr = 1'b0;
    is_dbl  = 1'b0;
    if (par) begin
      // A syndrome pointing past the codeword cannot be a single flip.
      if (int'(syn) > CW - 1) is_dbl = 1'b1;
      else begin
        fixed[syn] = ~fixed[syn];
        is_corr    = 1'b1;
      end
    end else if (syn != '0) begin
      is_dbl = 1'b1;
    end
    dec_word = AW'(extract(fixed));
`ifdef HAMMING_ERR_FLAG_EN
    dec_word[8*DB-1] = is_dbl;
    dec_word[8*DB-2] = is_corr;
`endif
    enc_word = AW'(encode(asm_q[DATA_W-1:0]));
  end

  logic [1:0]        src_last, dst_last;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [4:0]        sh;
  logic              last_msg;

  assign src_last = mode_q ? 2'(CB - 1) : 2'(DB - 1);
  assign dst_last = mode_q ? 2'(DB - 1) : 2'(CB - 1);
  assign rd_addr  = ADDR_W'(SRC_BASE + int'(idx) * (mode_q ? CB : DB) + int'(bcnt));
  assign wr_addr  = ADDR_W'(DST_BASE + int'(idx) * (mode_q ? DB : CB) + int'(bcnt));
  assign sh       = {bcnt, 3'b000};
  assign last_msg = (idx == 8'(NUM_MSG - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      bcnt   <= '0;
      asm_q  <= '0;
      out_q  <= '0;
      mode_q <= 1'b0;
      corr_q <= '0;
      dbl_q  <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE, DONE: if (bus.req) begin
          idx    <= '0;
          bcnt   <= '0;
          mode_q <= bus.mode;
          corr_q <= '0;
          dbl_q  <= '0;
        end
        RD: begin
          asm_q <= (asm_q & ~(AW'(8'hFF) << sh)) | (AW'(bus.mem_rd_data) << sh);
          bcnt  <= (bcnt == src_last) ? 2'd0 : bcnt + 2'd1;
        end
        CALC: begin
          out_q <= mode_q ? dec_word : enc_word;
          if (mode_q && is_corr && corr_q != 8'hFF) corr_q <= corr_q + 8'd1;
          if (mode_q && is_dbl  && dbl_q  != 8'hFF) dbl_q  <= dbl_q + 8'd1;
        end
        WR: begin
          if (bcnt == dst_last) begin
            bcnt <= '0;
            if (!last_msg) idx <= idx + 8'd1;
          end else begin
            bcnt <= bcnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n         = state;
    bus.ack         = 1'b0;
    bus.busy        = 1'b0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    case (state)
      IDLE: if (bus.req) state_n = RD;
      RD: begin
        bus.busy     = 1'b1;
        bus.mem_addr = rd_addr;
        if (bcnt == src_last) state_n = CALC;
      end
      CALC: begin
        bus.busy = 1'b1;
        state_n  = WR;
      end
      WR: begin
        bus.busy        = 1'b1;
        bus.mem_wr_en   = 1'b1;
        bus.mem_addr    = wr_addr;
        bus.mem_wr_data = 8'(out_q >> sh);
        if (bcnt == dst_last) state_n = last_msg ? DONE : RD;
      end
      DONE: begin
        bus.ack = 1'b1;
        if (bus.req) state_n = RD;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.corr_cnt = corr_q;
  assign bus.dbl_cnt  = dbl_q;
endmodule

// File: tb/tb_hamming_mem_engine.sv
// Scoreboard bench: default engine (11-bit data, 15 msgs) plus a 4-bit single-message engine.
module tb_hamming_mem_engine;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  hamming_mem_engine_if #(.ADDR_W(8)) bus1 ();
  hamming_mem_engine_if #(.ADDR_W(8)) bus2 ();

  hamming_mem_engine dut1 (.clk(clk), .reset(reset), .bus(bus1));
  hamming_mem_engine #(.DATA_W(4), .NUM_MSG(1)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  logic [7:0] mem1 [0:255];
  logic [7:0] mem2 [0:255];
  logic       tb_we1, tb_we2;
  logic [7:0] tb_a1, tb_d1, tb_a2, tb_d2;

  assign bus1.mem_rd_data = mem1[bus1.mem_addr];
  assign bus2.mem_rd_data = mem2[bus2.mem_addr];

  always @(posedge clk) begin
    if (bus1.mem_wr_en) mem1[bus1.mem_addr] <= bus1.mem_wr_data;
    else if (tb_we1)    mem1[tb_a1] <= tb_d1;
  end
  always @(posedge clk) begin
    if (bus2.mem_wr_en) mem2[bus2.mem_addr] <= bus2.mem_wr_data;
    else if (tb_we2)    mem2[tb_a2] <= tb_d2;
  end

  // Hand-computed codewords for the default 11-bit geometry.
  localparam logic [15:0] ENC_D [0:5] = '{16'h0001, 16'h07FF, 16'h0000, 16'h0002, 16'h0400, 16'h0555};
  localparam logic [15:0] ENC_C [0:5] = '{16'h000F, 16'hFFFF, 16'h0000, 16'h0033, 16'h8117, 16'hAA5A};
  // Decode vectors; class 0 clean, 1 corrected, 2 double. Messages 9..14 are clean zero.
  localparam logic [15:0] DEC_C [0:8] = '{16'h000F, 16'h020F, 16'h000E, 16'h000C, 16'hAA5A,
                                          16'hAA5B, 16'hFFF7, 16'hFFD7, 16'h0000};
  localparam logic [15:0] DEC_D [0:8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0555,
                                          16'h0555, 16'h07FF, 16'h07FC, 16'h0000};
  localparam int          DEC_K [0:8] = '{0, 1, 1, 2, 0, 1, 1, 2, 0};

  logic [15:0] q1 [$];
  logic [15:0] q2 [$];

  always @(negedge clk) begin
    if (bus1.mem_wr_en) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL wr1_unexpected act=%h exp=none", {bus1.mem_addr, bus1.mem_wr_data});
      end else begin
        logic [15:0] e;
        e = q1.pop_front();
        if ({bus1.mem_addr, bus1.mem_wr_data} !== e) begin
          errors++;
          $display("FAIL wr1 addr_data act=%h exp=%h", {bus1.mem_addr, bus1.mem_wr_data}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus2.mem_wr_en) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL wr2_unexpected act=%h exp=none", {bus2.mem_addr, bus2.mem_wr_data});
      end else begin
        logic [15:0] e;
        e = q2.pop_front();
        if ({bus2.mem_addr, bus2.mem_wr_data} !== e) begin
          errors++;
          $display("FAIL wr2 addr_data act=%h exp=%h", {bus2.mem_addr, bus2.mem_wr_data}, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic load1(input logic [7:0] a, input logic [7:0] d);
    tb_a1 = a; tb_d1 = d; tb_we1 = 1'b1;
    @(posedge clk); #1 tb_we1 = 1'b0;
  endtask

  task automatic load2(input logic [7:0] a, input logic [7:0] d);
    tb_a2 = a; tb_d2 = d; tb_we2 = 1'b1;
    @(posedge clk); #1 tb_we2 = 1'b0;
  endtask

  function automatic logic [15:0] dec_exp(input int i);
    logic [15:0] w;
    int          k;
    w = (i < 9) ? DEC_D[i] : 16'h0000;
    k = (i < 9) ? DEC_K[i] : 0;
`ifdef HAMMING_ERR_FLAG_EN
    if (k == 2) w[15] = 1'b1;
    if (k == 1) w[14] = 1'b1;
`endif
    return w;
  endfunction

  task automatic push_dec();
    for (int i = 0; i < 15; i++) begin
      logic [15:0] w;
      w = dec_exp(i);
      q1.push_back({8'(30 + 2 * i), w[7:0]});
      q1.push_back({8'(31 + 2 * i), w[15:8]});
    end
  endtask

  // Leaves the caller 1 time unit after the accept edge.
  task automatic start1(input logic m);
    @(posedge clk); #1 bus1.req = 1'b1; bus1.mode = m;
    @(posedge clk); #1 bus1.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus1.req = 1'b0; bus1.mode = 1'b0;
    bus2.req = 1'b0; bus2.mode = 1'b0;
    tb_we1 = 1'b0; tb_we2 = 1'b0;
    tb_a1 = '0; tb_d1 = '0; tb_a2 = '0; tb_d2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(bus1.ack), 0);
    chk("rst_busy", 32'(bus1.busy), 0);
    chk("rst_wr_en", 32'(bus1.mem_wr_en), 0);
    chk("rst_addr", 32'(bus1.mem_addr), 0);
    chk("rst_wdata", 32'(bus1.mem_wr_data), 0);
    chk("rst_corr", 32'(bus1.corr_cnt), 0);
    chk("rst_dbl", 32'(bus1.dbl_cnt), 0);
    reset = 1'b0;

    // 4-bit engine, req held across DONE restarts the job.
    load2(8'd0, 8'h01);
    q2.push_back({8'd30, 8'h0F});
    q2.push_back({8'd30, 8'h0F});
    @(posedge clk); #1 bus2.req = 1'b1;
    @(posedge clk); #1 chk("w4_busy_start", 32'(bus2.busy), 1);
    @(posedge clk); @(posedge clk); #1 chk("w4_ack_early", 32'(bus2.ack), 0);
    @(posedge clk); #1 chk("w4_ack_3cyc", 32'(bus2.ack), 1);
    chk("w4_busy_done", 32'(bus2.busy), 0);
    @(posedge clk); #1 chk("w4_restart_ack", 32'(bus2.ack), 0);
    chk("w4_restart_busy", 32'(bus2.busy), 1);
    bus2.req = 1'b0;
    repeat (3) @(posedge clk); #1 chk("w4_ack_again", 32'(bus2.ack), 1);

    // Encode job; a req and mode change mid-job must be ignored.
    for (int i = 0; i < 15; i++) begin
      logic [15:0] d, c;
      d = ENC_D[i % 6];
      c = ENC_C[i % 6];
      load1(8'(2 * i), d[7:0]);
      load1(8'(2 * i + 1), d[15:8]);
      q1.push_back({8'(30 + 2 * i), c[7:0]});
      q1.push_back({8'(31 + 2 * i), c[15:8]});
    end
    start1(1'b0);
    repeat (10) @(posedge clk);
    #1 bus1.req = 1'b1; bus1.mode = 1'b1;
    @(posedge clk); #1 bus1.req = 1'b0;
    repeat (63) @(posedge clk);
    #1 chk("enc_ack_74", 32'(bus1.ack), 0);
    @(posedge clk); #1 chk("enc_ack_75", 32'(bus1.ack), 1);
    chk("enc_busy_done", 32'(bus1.busy), 0);
    chk("enc_corr", 32'(bus1.corr_cnt), 0);
    chk("enc_dbl", 32'(bus1.dbl_cnt), 0);
    chk("enc_q_drained", 32'(q1.size()), 0);

    // Decode job with clean, single, bit-0 and double-error words.
    for (int i = 0; i < 15; i++) begin
      logic [15:0] c;
      c = (i < 9) ? DEC_C[i] : 16'h0000;
      load1(8'(2 * i), c[7:0]);
      load1(8'(2 * i + 1), c[15:8]);
    end
    push_dec();
    start1(1'b1);
    repeat (75) @(posedge clk);
    #1 chk("dec_ack", 32'(bus1.ack), 1);
    chk("dec_corr", 32'(bus1.corr_cnt), 4);
    chk("dec_dbl", 32'(bus1.dbl_cnt), 2);
    chk("dec_q_drained", 32'(q1.size()), 0);

    // Restart clears counters; reset during message 7 aborts.
    push_dec();
    start1(1'b1);
    chk("restart_corr", 32'(bus1.corr_cnt), 0);
    chk("restart_dbl", 32'(bus1.dbl_cnt), 0);
    chk("restart_ack", 32'(bus1.ack), 0);
    repeat (37) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_busy", 32'(bus1.busy), 0);
    chk("abort_ack", 32'(bus1.ack), 0);
    chk("abort_pending", 32'(q1.size()), 16);
    q1.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("abort_no_ack", 32'(bus1.ack), 0);
    chk("abort_idle_busy", 32'(bus1.busy), 0);
    chk("w4_q_drained", 32'(q2.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
